// File: rtl/dtree_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dtree_pkg
// Description : Shared types and widths for the dtree feeder front end.
// Revision    : 1.0 - initial release
// ============================================================================
package dtree_pkg;

  // Result field widths, shared with the dtree classifier core
  localparam int LEVEL_WIDTH = 2;
  localparam int PATH_WIDTH  = 2;

  // Feeder sequencing states
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_EMIT = 2'd3
  } feeder_state_t;

  // Index width for an N-entry buffer; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dtree_feature_buf.sv
`default_nettype none
// ============================================================================
// Module      : dtree_feature_buf
// Description : FEATURES x IN_WIDTH register file, synchronous write and
//               asynchronous read. Data is not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dtree_feature_buf #(
  parameter int FEATURES   = 3,
  parameter int IN_WIDTH   = 10,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [IN_WIDTH-1:0]   wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [IN_WIDTH-1:0]   rdata
);

  logic [IN_WIDTH-1:0] r_mem [FEATURES];

  // Write one feature sample per enabled cycle
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/dtree_feeder.sv
`default_nettype none
// ============================================================================
// Module      : dtree_feeder
// Description : Collects FEATURES upstream samples, replays them into dtree,
//               captures the level/path result and hands it downstream with
//               a running vector index. Flags unexpected dtree results.
// Revision    : 1.0 - initial release
// ============================================================================
module dtree_feeder
  import dtree_pkg::*;
#(
  parameter int FEATURES  = 3,
  parameter int IN_WIDTH  = 10,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [IN_WIDTH-1:0]    in_sample,
  output logic                   in_ready,
  input  logic                   dt_ready,
  output logic                   dt_valid,
  output logic [IN_WIDTH-1:0]    dt_sample,
  input  logic [LEVEL_WIDTH-1:0] dt_level,
  input  logic [PATH_WIDTH-1:0]  dt_path,
  input  logic                   dt_out_valid,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [LEVEL_WIDTH-1:0] res_level,
  output logic [PATH_WIDTH-1:0]  res_path,
  output logic [CNT_WIDTH-1:0]   res_index,
  output logic                   proto_err
);

  localparam int AW = idx_width(FEATURES);
  localparam logic [AW-1:0] c_last_idx = AW'(FEATURES - 1);

  feeder_state_t r_state;
  feeder_state_t w_next_state;
  logic [AW-1:0] r_wr_idx;
  logic [AW-1:0] r_rd_idx;
  logic          w_wr_fire;
  logic          w_rd_fire;

  dtree_feature_buf #(
    .FEATURES   (FEATURES),
    .IN_WIDTH   (IN_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_buf (
    .clk   (clk),
    .we    (w_wr_fire),
    .waddr (r_wr_idx),
    .wdata (in_sample),
    .raddr (r_rd_idx),
    .rdata (dt_sample)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake decode; each handshake is a pure state decode
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    dt_valid     = 1'b0;
    res_valid    = 1'b0;
    w_wr_fire    = 1'b0;
    w_rd_fire    = 1'b0;
    case (r_state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_wr_fire = 1'b1;
          if (r_wr_idx == c_last_idx) w_next_state = ST_SEND;
        end
      end
      ST_SEND: begin
        dt_valid = 1'b1;
        if (dt_ready) begin
          w_rd_fire = 1'b1;
          if (r_rd_idx == c_last_idx) w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dt_out_valid) w_next_state = ST_EMIT;
      end
      ST_EMIT: begin
        res_valid = 1'b1;
        if (res_ready) w_next_state = ST_LOAD;
      end
      default: w_next_state = ST_LOAD;
    endcase
  end

  // Buffer indices, result capture, vector index and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
      res_level <= '0;
      res_path  <= '0;
      res_index <= '0;
      proto_err <= 1'b0;
    end else begin
      if (w_wr_fire) begin
        if (r_wr_idx == c_last_idx) begin
          // Vector complete: both indices restart for the replay
          r_wr_idx <= '0;
          r_rd_idx <= '0;
        end else begin
          r_wr_idx <= r_wr_idx + AW'(1);
        end
      end
      if (w_rd_fire) begin
        r_rd_idx <= (r_rd_idx == c_last_idx) ? '0 : r_rd_idx + AW'(1);
      end
      if (r_state == ST_WAIT && dt_out_valid) begin
        res_level <= dt_level;
        res_path  <= dt_path;
      end
      if (r_state == ST_EMIT && res_ready) begin
        res_index <= res_index + CNT_WIDTH'(1);
      end
      // A result outside WAIT is never captured, only flagged
      if (r_state != ST_WAIT && dt_out_valid) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dtree_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dtree_feeder
// Description : Directed self-checking bench for dtree_feeder (FEATURES=3,
//               IN_WIDTH=10, CNT_WIDTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dtree_feeder;

  localparam int FEATURES  = 3;
  localparam int IN_WIDTH  = 10;
  localparam int CNT_WIDTH = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic [IN_WIDTH-1:0]  in_sample;
  logic                 in_ready;
  logic                 dt_ready;
  logic                 dt_valid;
  logic [IN_WIDTH-1:0]  dt_sample;
  logic [1:0]           dt_level;
  logic [1:0]           dt_path;
  logic                 dt_out_valid;
  logic                 res_valid;
  logic                 res_ready;
  logic [1:0]           res_level;
  logic [1:0]           res_path;
  logic [CNT_WIDTH-1:0] res_index;
  logic                 proto_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CNT_WIDTH-1:0] exp_idx;
  logic [IN_WIDTH-1:0]  sent_q[$];
  logic [IN_WIDTH-1:0]  held_q[$];
  int send_cycles;

  dtree_feeder #(
    .FEATURES  (FEATURES),
    .IN_WIDTH  (IN_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_sample    (in_sample),
    .in_ready     (in_ready),
    .dt_ready     (dt_ready),
    .dt_valid     (dt_valid),
    .dt_sample    (dt_sample),
    .dt_level     (dt_level),
    .dt_path      (dt_path),
    .dt_out_valid (dt_out_valid),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_level    (res_level),
    .res_path     (res_path),
    .res_index    (res_index),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vector(input logic [IN_WIDTH-1:0] a, b, c);
    logic [IN_WIDTH-1:0] v [3];
    v = '{a, b, c};
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_sample = v[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Drives dt_ready from the stall mask while SEND lasts (bounded to 20 cycles)
  task automatic run_send(input logic [31:0] stall_mask);
    sent_q.delete();
    held_q.delete();
    send_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      if (!dt_valid) break;
      dt_ready = !stall_mask[c];
      if (dt_ready) sent_q.push_back(dt_sample);
      else          held_q.push_back(dt_sample);
      tick();
      send_cycles++;
    end
    dt_ready = 1'b1;
  endtask

  task automatic pulse_result(input int delay, input logic [1:0] lvl, input logic [1:0] pth);
    repeat (delay) tick();
    dt_level     = lvl;
    dt_path      = pth;
    dt_out_valid = 1'b1;
    tick();
    dt_out_valid = 1'b0;
    dt_level     = 2'd0;
    dt_path      = 2'd0;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_idx   = exp_idx + 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (dt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dt_valid: got %b expected 0", dt_valid); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    n_checks++; if (res_level !== 2'd0 || res_path !== 2'd0) begin n_fail++; $display("FAIL reset_res_fields: got level %0d path %0d expected 0 0", res_level, res_path); end
    n_checks++; if (res_index !== 2'd0) begin n_fail++; $display("FAIL reset_res_index: got %0d expected 0", res_index); end
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %b expected 0", proto_err); end
    exp_idx = '0;
  endtask

  task automatic test_basic();
    logic [IN_WIDTH-1:0] e [3];
    logic [IN_WIDTH-1:0] g;
    e = '{10'd100, 10'd200, 10'd300};
    load_vector(10'd100, 10'd200, 10'd300);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready_after_load: got %b expected 0", in_ready); end
    n_checks++; if (dt_valid !== 1'b1 || dt_sample !== 10'd100) begin n_fail++; $display("FAIL basic_first_sample: got valid %b sample %0d expected 1 100", dt_valid, dt_sample); end
    run_send(32'd0);
    n_checks++; if (sent_q.size() !== 3 || send_cycles !== 3) begin n_fail++; $display("FAIL basic_transfer_count: got %0d in %0d cycles expected 3 in 3", sent_q.size(), send_cycles); end
    for (int i = 0; i < 3; i++) begin
      g = (i < sent_q.size()) ? sent_q[i] : 'x;
      n_checks++; if (g !== e[i]) begin n_fail++; $display("FAIL basic_sample_%0d: got %0d expected %0d", i, g, e[i]); end
    end
    n_checks++; if (dt_valid !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_wait_idle: got dt_valid %b res_valid %b expected 0 0", dt_valid, res_valid); end
    pulse_result(2, 2'd2, 2'b10);
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL basic_res_valid: got %b expected 1", res_valid); end
    n_checks++; if (res_level !== 2'd2 || res_path !== 2'b10) begin n_fail++; $display("FAIL basic_res_fields: got level %0d path %b expected 2 10", res_level, res_path); end
    n_checks++; if (res_index !== 2'd0) begin n_fail++; $display("FAIL basic_res_index: got %0d expected 0", res_index); end
    consume();
    n_checks++; if (in_ready !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_back_to_load: got in_ready %b res_valid %b expected 1 0", in_ready, res_valid); end
  endtask

  task automatic test_stall();
    logic [IN_WIDTH-1:0] e [3];
    logic [IN_WIDTH-1:0] g;
    e = '{10'd100, 10'd200, 10'd300};
    load_vector(10'd100, 10'd200, 10'd300);
    run_send(32'b0110);
    n_checks++; if (sent_q.size() !== 3 || send_cycles !== 5) begin n_fail++; $display("FAIL stall_transfer_count: got %0d in %0d cycles expected 3 in 5", sent_q.size(), send_cycles); end
    for (int i = 0; i < 3; i++) begin
      g = (i < sent_q.size()) ? sent_q[i] : 'x;
      n_checks++; if (g !== e[i]) begin n_fail++; $display("FAIL stall_sample_%0d: got %0d expected %0d", i, g, e[i]); end
    end
    n_checks++; if (held_q.size() !== 2) begin n_fail++; $display("FAIL stall_held_count: got %0d expected 2", held_q.size()); end
    for (int i = 0; i < held_q.size(); i++) begin
      n_checks++; if (held_q[i] !== 10'd200) begin n_fail++; $display("FAIL stall_held_%0d: got %0d expected 200", i, held_q[i]); end
    end
    pulse_result(0, 2'd1, 2'd1);
    n_checks++; if (res_index !== 2'd1) begin n_fail++; $display("FAIL stall_res_index: got %0d expected 1", res_index); end
    consume();
  endtask

  task automatic test_backpressure();
    logic [IN_WIDTH-1:0] e [3];
    logic [IN_WIDTH-1:0] g;
    e = '{10'd4, 10'd5, 10'd6};
    load_vector(10'd1, 10'd2, 10'd3);
    run_send(32'd0);
    pulse_result(1, 2'd1, 2'd3);
    res_ready = 1'b0;
    in_valid  = 1'b1;
    in_sample = 10'd55;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (res_valid !== 1'b1 || res_level !== 2'd1 || res_path !== 2'd3 || res_index !== 2'd2) begin n_fail++; $display("FAIL bp_res_stable_%0d: got v%b l%0d p%0d i%0d expected v1 l1 p3 i2", c, res_valid, res_level, res_path, res_index); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_%0d: got %b expected 0", c, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    consume();
    load_vector(10'd4, 10'd5, 10'd6);
    run_send(32'd0);
    for (int i = 0; i < 3; i++) begin
      g = (i < sent_q.size()) ? sent_q[i] : 'x;
      n_checks++; if (g !== e[i]) begin n_fail++; $display("FAIL bp_next_sample_%0d: got %0d expected %0d", i, g, e[i]); end
    end
    pulse_result(0, 2'd0, 2'd0);
    n_checks++; if (res_index !== 2'd3) begin n_fail++; $display("FAIL bp_next_index: got %0d expected 3", res_index); end
    consume();
  endtask

  task automatic test_index_wrap();
    logic [CNT_WIDTH-1:0] e [5];
    e = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_idx = '0;
    for (int v = 0; v < 5; v++) begin
      load_vector(IN_WIDTH'(v), IN_WIDTH'(v + 1), IN_WIDTH'(v + 2));
      run_send(32'd0);
      pulse_result(0, 2'(v), 2'(3 - v));
      n_checks++; if (res_valid !== 1'b1 || res_index !== e[v]) begin n_fail++; $display("FAIL wrap_index_%0d: got valid %b index %0d expected 1 %0d", v, res_valid, res_index, e[v]); end
      consume();
    end
  endtask

  task automatic test_spurious();
    n_checks++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL spur_pre_err: got %b expected 0", proto_err); end
    load_vector(10'd11, 10'd22, 10'd33);
    dt_ready     = 1'b1;
    dt_level     = 2'd3;
    dt_path      = 2'd1;
    dt_out_valid = 1'b1;
    tick();
    dt_out_valid = 1'b0;
    n_checks++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL spur_err_set: got %b expected 1", proto_err); end
    n_checks++; if (dt_valid !== 1'b1 || dt_sample !== 10'd22 || res_valid !== 1'b0) begin n_fail++; $display("FAIL spur_continues: got valid %b sample %0d res_valid %b expected 1 22 0", dt_valid, dt_sample, res_valid); end
    run_send(32'd0);
    n_checks++; if (sent_q.size() !== 2 || dt_valid !== 1'b0) begin n_fail++; $display("FAIL spur_remaining: got %0d transfers dt_valid %b expected 2 0", sent_q.size(), dt_valid); end
    pulse_result(1, 2'd1, 2'd2);
    n_checks++; if (res_valid !== 1'b1 || res_level !== 2'd1 || res_path !== 2'd2) begin n_fail++; $display("FAIL spur_capture: got v%b l%0d p%0d expected v1 l1 p2", res_valid, res_level, res_path); end
    n_checks++; if (res_index !== exp_idx) begin n_fail++; $display("FAIL spur_index: got %0d expected %0d", res_index, exp_idx); end
    consume();
    n_checks++; if (proto_err !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL spur_sticky: got err %b in_ready %b expected 1 1", proto_err, in_ready); end
  endtask

  task automatic test_reset_mid_send();
    logic [IN_WIDTH-1:0] e [3];
    logic [IN_WIDTH-1:0] g;
    e = '{10'd7, 10'd8, 10'd9};
    load_vector(10'd1, 10'd2, 10'd3);
    dt_ready = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || dt_valid !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_handshakes: got in_ready %b dt_valid %b res_valid %b expected 1 0 0", in_ready, dt_valid, res_valid); end
    n_checks++; if (res_level !== 2'd0 || res_path !== 2'd0 || res_index !== 2'd0 || proto_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_regs: got l%0d p%0d i%0d err%b expected 0 0 0 0", res_level, res_path, res_index, proto_err); end
    exp_idx = '0;
    load_vector(10'd7, 10'd8, 10'd9);
    run_send(32'd0);
    n_checks++; if (sent_q.size() !== 3) begin n_fail++; $display("FAIL rst_mid_count: got %0d expected 3", sent_q.size()); end
    for (int i = 0; i < 3; i++) begin
      g = (i < sent_q.size()) ? sent_q[i] : 'x;
      n_checks++; if (g !== e[i]) begin n_fail++; $display("FAIL rst_mid_sample_%0d: got %0d expected %0d", i, g, e[i]); end
    end
    pulse_result(0, 2'd2, 2'd1);
    n_checks++; if (res_valid !== 1'b1 || res_level !== 2'd2 || res_path !== 2'd1 || res_index !== 2'd0) begin n_fail++; $display("FAIL rst_mid_result: got v%b l%0d p%0d i%0d expected v1 l2 p1 i0", res_valid, res_level, res_path, res_index); end
    consume();
  endtask

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_sample    = '0;
    dt_ready     = 1'b1;
    dt_level     = 2'd0;
    dt_path      = 2'd0;
    dt_out_valid = 1'b0;
    res_ready    = 1'b0;
    exp_idx      = '0;
    test_reset();
    test_basic();
    test_stall();
    test_backpressure();
    test_index_wrap();
    test_spurious();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
